// File: rtl/blit_mem_pkg.sv
// rtl/blit_mem_pkg.sv - shared types, width codes and helpers for the blitter memory responder
package blit_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_WAITST = 2'd2,
    S_RDLAT  = 2'd3
  } bmem_state_t;

  localparam logic [3:0] W_BYTE   = 4'b0000;
  localparam logic [3:0] W_WORD   = 4'b0001;
  localparam logic [3:0] W_LONG   = 4'b0010;
  localparam logic [3:0] W_PHRASE = 4'b1000;

  localparam int PADDR_W = 21;

  // Byte count for a width code; undefined non-phrase codes fall back to a single byte
  function automatic logic [3:0] width_bytes(input logic [3:0] w);
    logic [3:0] n;
    if ((w & W_PHRASE) != 4'd0) begin
      n = 4'd8;
    end else begin
      case (w)
        W_BYTE:  n = 4'd1;
        W_WORD:  n = 4'd2;
        W_LONG:  n = 4'd4;
        default: n = 4'd1;
      endcase
    end
    return n;
  endfunction

  // Non-phrase code above the long encoding
  function automatic logic width_bad(input logic [3:0] w);
    return ((w & W_PHRASE) == 4'd0) && (w[2:0] > 3'b010);
  endfunction

  // Address low bits not aligned to the transfer size
  function automatic logic addr_misaligned(input logic [3:0] w, input logic [2:0] a);
    logic [2:0] m;
    m = 3'(width_bytes(w) - 4'd1);
    return (a & m) != 3'd0;
  endfunction

endpackage

// File: rtl/blit_lane_align.sv
// rtl/blit_lane_align.sv - combinational byte-lane mask generator and data shifter
module blit_lane_align
  import blit_mem_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  logic [3:0]  width,
  input  logic        justify,
  input  logic [63:0] wr_data,
  input  logic [63:0] rd_data,
  output logic [7:0]  be,
  output logic [63:0] wr_lanes,
  output logic [63:0] rd_lanes
);

  logic [3:0]  nbytes;
  logic [7:0]  nmask;
  logic [2:0]  lane;
  logic [5:0]  shamt;
  logic [63:0] keep;

  // Lane is the address aligned down to the transfer size; justified data moves between lane 0 and it
  always_comb begin
    nbytes = width_bytes(width);
    nmask  = (nbytes == 4'd8) ? 8'hFF : 8'((9'd1 << nbytes) - 9'd1);
    lane   = addr_lo & ~3'(nbytes - 4'd1);
    shamt  = {lane, 3'b000};
    be     = nmask << lane;
    keep   = '0;
    for (int i = 0; i < 8; i++) begin
      keep[i*8 +: 8] = {8{nmask[i]}};
    end
    wr_lanes = justify ? (wr_data << shamt) : wr_data;
    rd_lanes = justify ? ((rd_data >> shamt) & keep) : rd_data;
  end

endmodule

// File: rtl/blit_mem_responder.sv
// rtl/blit_mem_responder.sv - blitter bus responder with wait states and fixed-latency reads; optional checker via BMEM_ERRCHK_EN
module blit_mem_responder
  import blit_mem_pkg::*;
#(
  parameter int WAIT_CYC = 1,
  parameter int READ_LAT = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               blit_breq,
  output logic               blit_back,
  input  logic               mreq,
  input  logic               read,
  input  logic [3:0]         width,
  input  logic               justify,
  input  logic [23:0]        address,
  input  logic [63:0]        wdata,
  output logic               ack,
  output logic [63:0]        rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [PADDR_W-1:0] mem_addr,
  output logic [7:0]         mem_be,
  output logic [63:0]        mem_wdata,
  input  logic [63:0]        mem_rdata,
  output logic               proto_err
);

  localparam logic [2:0] WAIT3 = 3'(WAIT_CYC);
  localparam logic [2:0] RLAT3 = 3'(READ_LAT);

  bmem_state_t state, state_nxt;
  logic [2:0]  cnt;

  logic        lat_read, lat_justify;
  logic [3:0]  lat_width;
  logic [23:0] lat_addr;
  logic [63:0] lat_wdata;

  logic        cur_read, cur_justify;
  logic [3:0]  cur_width;
  logic [23:0] cur_addr;
  logic [63:0] cur_wdata;

  logic        addr_ack, data_ack, accept_bp, accept_new;
  logic [7:0]  be_raw;
  logic [63:0] wr_lanes, rd_lanes;

  assign addr_ack   = (state == S_WAITST) && (cnt == 3'd0);
  assign data_ack   = (state == S_RDLAT) && (cnt == 3'd0);
  assign accept_bp  = data_ack && mreq;
  assign accept_new = ((state == S_GRANT) && mreq) || accept_bp;

  // A request accepted on the data ack is issued the same cycle, so it bypasses the latches
  always_comb begin
    cur_read    = accept_bp ? read    : lat_read;
    cur_justify = accept_bp ? justify : lat_justify;
    cur_width   = accept_bp ? width   : lat_width;
    cur_addr    = accept_bp ? address : lat_addr;
    cur_wdata   = accept_bp ? wdata   : lat_wdata;
  end

  blit_lane_align u_align (
    .addr_lo  (cur_addr[2:0]),
    .width    (cur_width),
    .justify  (cur_justify),
    .wr_data  (cur_wdata),
    .rd_data  (mem_rdata),
    .be       (be_raw),
    .wr_lanes (wr_lanes),
    .rd_lanes (rd_lanes)
  );

  assign mem_addr  = cur_addr[23:3];
  assign mem_wdata = wr_lanes;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a dropped breq only takes effect once back in GRANT
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (blit_breq) state_nxt = S_GRANT;
      S_GRANT: begin
        if (mreq)            state_nxt = S_WAITST;
        else if (!blit_breq) state_nxt = S_IDLE;
      end
      S_WAITST: if (cnt == 3'd0) state_nxt = lat_read ? S_RDLAT : S_GRANT;
      S_RDLAT:  if (cnt == 3'd0) state_nxt = (mreq && read) ? S_RDLAT : S_GRANT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode: one ack serves the address phase, the data phase, or both at once
  always_comb begin
    ack     = addr_ack || data_ack;
    mem_req = addr_ack || accept_bp;
    mem_we  = mem_req && !cur_read;
    mem_be  = mem_req ? be_raw : 8'h00;
  end

  // Counter, request latches, read-data register and grant; grant drops one cycle after IDLE is reached
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= 3'd0;
      lat_read    <= 1'b0;
      lat_justify <= 1'b0;
      lat_width   <= 4'd0;
      lat_addr    <= 24'd0;
      lat_wdata   <= 64'd0;
      rdata       <= 64'd0;
      blit_back   <= 1'b0;
    end else begin
      blit_back <= (state_nxt != S_IDLE) || (state != S_IDLE);
      case (state)
        S_GRANT:  if (mreq) cnt <= WAIT3;
        S_WAITST: cnt <= (cnt == 3'd0) ? RLAT3 : cnt - 3'd1;
        S_RDLAT:  cnt <= (cnt == 3'd0) ? RLAT3 : cnt - 3'd1;
        default:  cnt <= 3'd0;
      endcase
      if (accept_new) begin
        lat_read    <= read;
        lat_justify <= justify;
        lat_width   <= width;
        lat_addr    <= address;
        lat_wdata   <= wdata;
      end
      if ((state == S_RDLAT) && (cnt == 3'd1)) begin
        rdata <= rd_lanes;
      end
    end
  end

`ifdef BMEM_ERRCHK_EN
  logic err_now;

  // Flag a bad request code/alignment at acceptance, or mreq dropped before its ack
  always_comb begin
    err_now = (accept_new && (width_bad(width) || addr_misaligned(width, address[2:0])))
           || ((state == S_WAITST) && !mreq);
  end

  // Sticky until reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      proto_err <= 1'b0;
    end else if (err_now) begin
      proto_err <= 1'b1;
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_blit_mem_responder.sv
// tb/tb_blit_mem_responder.sv - directed self-checking bench for blit_mem_responder
module tb_blit_mem_responder;

  logic        clk;
  logic        reset_n;
  logic        blit_breq;
  logic        blit_back;
  logic        mreq;
  logic        read;
  logic [3:0]  width;
  logic        justify;
  logic [23:0] address;
  logic [63:0] wdata;
  logic        ack;
  logic [63:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [20:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        proto_err;

  int total;
  int fails;
  logic exp_err;

  blit_mem_responder #(.WAIT_CYC(1), .READ_LAT(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .blit_breq (blit_breq),
    .blit_back (blit_back),
    .mreq      (mreq),
    .read      (read),
    .width     (width),
    .justify   (justify),
    .address   (address),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input logic rd, input logic [3:0] w, input logic j,
                         input logic [23:0] a, input logic [63:0] wd);
    mreq    = 1'b1;
    read    = rd;
    width   = w;
    justify = j;
    address = a;
    wdata   = wd;
  endtask

  initial begin
    total = 0;
    fails = 0;
`ifdef BMEM_ERRCHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    reset_n   = 1'b0;
    blit_breq = 1'b0;
    mreq      = 1'b0;
    read      = 1'b0;
    width     = 4'd0;
    justify   = 1'b0;
    address   = 24'd0;
    wdata     = 64'd0;
    mem_rdata = 64'd0;
    tick();
    tick();

    chk("rst_back", blit_back, 1'b0);
    chk("rst_ack", ack, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_be", mem_be, 8'h00);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_mem_addr", mem_addr, 21'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_proto_err", proto_err, 1'b0);
    reset_n = 1'b1;

    // grant and release
    blit_breq = 1'b1;
    tick();
    chk("grant_back", blit_back, 1'b1);
    blit_breq = 1'b0;
    tick();
    chk("release_back_hold", blit_back, 1'b1);
    tick();
    chk("release_back_low", blit_back, 1'b0);

    // long justified write, WAIT_CYC=1
    blit_breq = 1'b1;
    tick();
    chk("grant2_back", blit_back, 1'b1);
    set_req(1'b0, 4'b0010, 1'b1, 24'h001004, 64'h11223344);
    tick();
    chk("wr_wait_ack", ack, 1'b0);
    chk("wr_wait_mem_req", mem_req, 1'b0);
    tick();
    chk("wr_ack", ack, 1'b1);
    chk("wr_mem_req", mem_req, 1'b1);
    chk("wr_mem_we", mem_we, 1'b1);
    chk("wr_mem_addr", mem_addr, 21'h000200);
    chk("wr_mem_be", mem_be, 8'hF0);
    chk("wr_mem_wdata", mem_wdata, 64'h11223344_00000000);
    tick();
    mreq = 1'b0;
    chk("wr_after_ack", ack, 1'b0);
    chk("wr_proto_err", proto_err, 1'b0);

    // phrase read, READ_LAT=2
    set_req(1'b1, 4'b1000, 1'b0, 24'h000040, 64'd0);
    tick();
    chk("prd_wait_ack", ack, 1'b0);
    tick();
    chk("prd_ack", ack, 1'b1);
    chk("prd_mem_req", mem_req, 1'b1);
    chk("prd_mem_we", mem_we, 1'b0);
    chk("prd_mem_be", mem_be, 8'hFF);
    chk("prd_mem_addr", mem_addr, 21'h000008);
    tick();
    mreq = 1'b0;
    chk("prd_lat1_ack", ack, 1'b0);
    tick();
    mem_rdata = 64'h0123456789ABCDEF;
    chk("prd_lat2_ack", ack, 1'b0);
    tick();
    mem_rdata = 64'd0;
    chk("prd_data_ack", ack, 1'b1);
    chk("prd_rdata", rdata, 64'h0123456789ABCDEF);
    chk("prd_data_mem_req", mem_req, 1'b0);
    tick();
    chk("prd_after_ack", ack, 1'b0);

    // justified byte read from lane 5
    set_req(1'b1, 4'b0000, 1'b1, 24'h000105, 64'd0);
    tick();
    tick();
    chk("brd_ack", ack, 1'b1);
    chk("brd_mem_be", mem_be, 8'h20);
    tick();
    mreq = 1'b0;
    tick();
    mem_rdata = 64'h11225A44_55667788;
    tick();
    mem_rdata = 64'd0;
    chk("brd_data_ack", ack, 1'b1);
    chk("brd_rdata", rdata, 64'h5A);
    tick();

    // back-to-back phrase reads, mreq held across the data ack
    set_req(1'b1, 4'b1000, 1'b0, 24'h000200, 64'd0);
    tick();
    tick();
    chk("b2b_ack1", ack, 1'b1);
    chk("b2b_mem_addr1", mem_addr, 21'h000040);
    address = 24'h000300;
    tick();
    tick();
    mem_rdata = 64'hAAAA0000_11112222;
    tick();
    mem_rdata = 64'd0;
    chk("b2b_data_ack1", ack, 1'b1);
    chk("b2b_rdata1", rdata, 64'hAAAA0000_11112222);
    chk("b2b_mem_req2", mem_req, 1'b1);
    chk("b2b_mem_we2", mem_we, 1'b0);
    chk("b2b_mem_addr2", mem_addr, 21'h000060);
    tick();
    mreq = 1'b0;
    chk("b2b_gap_ack", ack, 1'b0);
    tick();
    mem_rdata = 64'h33334444_55556666;
    chk("b2b_gap2_ack", ack, 1'b0);
    tick();
    mem_rdata = 64'd0;
    chk("b2b_data_ack2", ack, 1'b1);
    chk("b2b_rdata2", rdata, 64'h33334444_55556666);
    tick();
    chk("b2b_proto_err", proto_err, 1'b0);

    // reset during RDLAT
    set_req(1'b1, 4'b1000, 1'b0, 24'h000000, 64'd0);
    tick();
    tick();
    chk("rrst_ack_addr", ack, 1'b1);
    tick();
    mreq = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rrst_back", blit_back, 1'b0);
    chk("rrst_ack", ack, 1'b0);
    chk("rrst_mem_req", mem_req, 1'b0);
    chk("rrst_rdata", rdata, 64'd0);
    chk("rrst_mem_be", mem_be, 8'h00);
    mem_rdata = 64'hDEADBEEF_DEADBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rrst_no_ack", ack, 1'b0);
    end
    mem_rdata = 64'd0;
    blit_breq = 1'b0;
    reset_n = 1'b1;
    tick();

    // undefined width code
    blit_breq = 1'b1;
    tick();
    set_req(1'b0, 4'b0111, 1'b0, 24'h000010, 64'd0);
    tick();
    chk("err_set", proto_err, exp_err);
    tick();
    chk("err_ack", ack, 1'b1);
    tick();
    mreq = 1'b0;
    blit_breq = 1'b0;
    tick();
    tick();
    chk("err_sticky", proto_err, exp_err);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
